// File: rtl/conv3x3_stream.sv
// Streaming 3x3 gradient convolver (Sobel / Scharr / Prewitt) with two row delay lines,
// run-time line width, frame-start resync and one backpressured output register.
module conv3x3_stream #(
    parameter int WIDTH_P = 8,
    parameter int DEPTH_P = 16,
    parameter int CW_P    = $clog2(DEPTH_P + 1)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [WIDTH_P-1:0]          data_i,
    input  logic                        sof_i,
    input  logic [CW_P-1:0]             width_i,
    input  logic [1:0]                  mode_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic signed [2*WIDTH_P-1:0] gx_o,
    output logic signed [2*WIDTH_P-1:0] gy_o,
    output logic                        eol_o
);
    localparam int OW = 2 * WIDTH_P;
    localparam int AW = $clog2(DEPTH_P);
    localparam logic [CW_P-1:0] MAX_W = CW_P'(DEPTH_P);
    localparam logic [CW_P-1:0] MIN_W = CW_P'(3);

    typedef enum logic [1:0] {
        KERN_SOBEL   = 2'd0,
        KERN_SCHARR  = 2'd1,
        KERN_PREWITT = 2'd2,
        KERN_RSVD    = 2'd3
    } kern_e;

    typedef logic [WIDTH_P-1:0] pix_t;
    typedef logic [OW-1:0]      acc_t;

    function automatic acc_t weight_outer(input pix_t p, input kern_e k);
        acc_t e;
        e = acc_t'(p);
        case (k)
            KERN_SCHARR: weight_outer = (e << 1) + e;
            default:     weight_outer = e;
        endcase
    endfunction

    function automatic acc_t weight_center(input pix_t p, input kern_e k);
        acc_t e;
        e = acc_t'(p);
        case (k)
            KERN_SCHARR:  weight_center = (e << 3) + (e << 1);
            KERN_PREWITT: weight_center = e;
            default:      weight_center = e << 1;
        endcase
    endfunction

    logic [CW_P-1:0] col_q;
    logic [CW_P-1:0] width_q;
    logic [1:0]      row_q;
    kern_e           mode_q;

    // lb_near holds the previous row, lb_far the row before that; both indexed by column.
    pix_t lb_near [DEPTH_P];
    pix_t lb_far  [DEPTH_P];

    // Only the left and centre window columns are stored; the right column is the incoming beat.
    pix_t win_q [3][2];

    logic            accept;
    logic [CW_P-1:0] clamped_width;
    logic [CW_P-1:0] cur_col;
    logic [CW_P-1:0] cur_width;
    logic [1:0]      cur_row;
    kern_e           cur_mode;
    logic [AW-1:0]   lb_addr;
    pix_t            new_top;
    pix_t            new_mid;
    pix_t            new_bot;
    logic            last_col;
    logic            win_valid;
    acc_t            sum_left;
    acc_t            sum_right;
    acc_t            sum_top;
    acc_t            sum_bottom;

    assign ready_o = ready_i | ~valid_o;
    assign accept  = valid_i & ready_o;

    always_comb begin
        clamped_width = width_i;
        if (width_i < MIN_W) begin
            clamped_width = MIN_W;
        end else if (width_i > MAX_W) begin
            clamped_width = MAX_W;
        end
    end

    // A frame-start beat is processed as column 0 / row 0 with its own width and kernel.
    always_comb begin
        cur_col   = sof_i ? '0 : col_q;
        cur_row   = sof_i ? '0 : row_q;
        cur_width = sof_i ? clamped_width : width_q;
        cur_mode  = sof_i ? kern_e'(mode_i) : mode_q;
        lb_addr   = cur_col[AW-1:0];
        new_top   = lb_far[lb_addr];
        new_mid   = lb_near[lb_addr];
        new_bot   = data_i;
        last_col  = (cur_col == cur_width - CW_P'(1));
        win_valid = (cur_row == 2'd2) && (cur_col >= CW_P'(2));

        sum_left   = weight_outer(win_q[0][0], cur_mode) + weight_center(win_q[1][0], cur_mode)
                   + weight_outer(win_q[2][0], cur_mode);
        sum_right  = weight_outer(new_top, cur_mode) + weight_center(new_mid, cur_mode)
                   + weight_outer(new_bot, cur_mode);
        sum_top    = weight_outer(win_q[0][0], cur_mode) + weight_center(win_q[0][1], cur_mode)
                   + weight_outer(new_top, cur_mode);
        sum_bottom = weight_outer(win_q[2][0], cur_mode) + weight_center(win_q[2][1], cur_mode)
                   + weight_outer(new_bot, cur_mode);
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb_far[lb_addr]  <= lb_near[lb_addr];
            lb_near[lb_addr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            col_q   <= '0;
            row_q   <= '0;
            width_q <= MAX_W;
            mode_q  <= KERN_SOBEL;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            width_q <= cur_width;
            mode_q  <= cur_mode;
            col_q   <= last_col ? '0 : cur_col + CW_P'(1);
            if (last_col && (cur_row != 2'd2)) begin
                row_q <= cur_row + 2'd1;
            end else begin
                row_q <= cur_row;
            end
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
            end
            win_q[0][1] <= new_top;
            win_q[1][1] <= new_mid;
            win_q[2][1] <= new_bot;
        end
    end

    // Output register: loads on a valid window, holds while stalled, empties when drained.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            valid_o <= 1'b0;
            gx_o    <= '0;
            gy_o    <= '0;
            eol_o   <= 1'b0;
        end else if (accept && win_valid) begin
            valid_o <= 1'b1;
            gx_o    <= signed'(sum_right - sum_left);
            gy_o    <= signed'(sum_bottom - sum_top);
            eol_o   <= last_col;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Table-driven bench for conv3x3_stream: kernels, width clamping, step edge, backpressure,
// mid-frame frame-start and mid-row reset.
module tb_conv3x3_stream;
    localparam int WIDTH_P = 8;
    localparam int DEPTH_P = 16;
    localparam int CW_P    = $clog2(DEPTH_P + 1);
    localparam int OW      = 2 * WIDTH_P;

    localparam int PAT_CONST = 0;
    localparam int PAT_COL   = 1;
    localparam int PAT_ROW10 = 2;
    localparam int PAT_STEP  = 3;
    localparam int PAT_RAND  = 4;
    localparam int PAT_ROW20 = 5;

    typedef struct {
        int width_in;
        int w_eff;
        int mode;
        int pat;
        int rows;
        int exp_count;
        int exp_gx;
        int exp_gy;
    } vec_t;

    typedef struct {
        int gx;
        int gy;
        int eol;
    } out_t;

    logic                 clk_i   = 1'b0;
    logic                 rstn_i  = 1'b0;
    logic                 valid_i = 1'b0;
    logic                 ready_o;
    logic [WIDTH_P-1:0]   data_i  = '0;
    logic                 sof_i   = 1'b0;
    logic [CW_P-1:0]      width_i = '0;
    logic [1:0]           mode_i  = '0;
    logic                 valid_o;
    logic                 ready_i = 1'b1;
    logic signed [OW-1:0] gx_o;
    logic signed [OW-1:0] gy_o;
    logic                 eol_o;

    int   n_compared = 0;
    int   n_failed   = 0;
    int   ready_mode = 0;
    out_t got_q[$];
    out_t exp_q[$];
    int   img [0:5][0:15];
    bit   was_stalled = 1'b0;
    out_t held;

    conv3x3_stream #(.WIDTH_P(WIDTH_P), .DEPTH_P(DEPTH_P)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .sof_i   (sof_i),
        .width_i (width_i),
        .mode_i  (mode_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .gx_o    (gx_o),
        .gy_o    (gy_o),
        .eol_o   (eol_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int pixAt(input int pat, input int r, input int c);
        case (pat)
            PAT_CONST: return 100;
            PAT_COL:   return c;
            PAT_ROW10: return 10 * r;
            PAT_STEP:  return (c >= 3) ? 255 : 0;
            PAT_RAND:  return img[r][c];
            default:   return 20 * r;
        endcase
    endfunction

    // One beat: present at the falling edge, hold until ready_o is seen ahead of a rising edge.
    task automatic applyStimulus(input int pix, input bit sof, input int w, input int m);
        int guard;
        bit done;
        guard = 0;
        done  = 1'b0;
        @(negedge clk_i);
        valid_i = 1'b1;
        data_i  = WIDTH_P'(pix);
        sof_i   = sof;
        width_i = CW_P'(w);
        mode_i  = 2'(m);
        while (!done) begin
            #1;
            if (ready_o) begin
                @(posedge clk_i);
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 200) begin
                    $display("[TB] FAIL input_accept_timeout: got ready_o=0 for %0d cycles, expected 1", guard);
                    $fatal(1, "[TB] input never accepted");
                end
                @(negedge clk_i);
            end
        end
    endtask

    task automatic endStream();
        @(negedge clk_i);
        valid_i = 1'b0;
        sof_i   = 1'b0;
    endtask

    task automatic sendFrame(input int pat, input int w_in, input int w_eff, input int m, input int beats);
        for (int k = 0; k < beats; k++) begin
            applyStimulus(pixAt(pat, k / w_eff, k % w_eff), (k == 0), w_in, m);
        end
        endStream();
    endtask

    task automatic pushExp(input int gx, input int gy, input int eol);
        out_t e;
        e.gx  = gx;
        e.gy  = gy;
        e.eol = eol;
        exp_q.push_back(e);
    endtask

    task automatic compareAll(input string name);
        int waited;
        waited = 0;
        while ((got_q.size() < exp_q.size()) && (waited < 600)) begin
            @(negedge clk_i);
            waited++;
        end
        repeat (6) @(negedge clk_i);
        checkOutput({name, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; (i < exp_q.size()) && (i < got_q.size()); i++) begin
            checkOutput($sformatf("%s gx[%0d]", name, i), got_q[i].gx, exp_q[i].gx);
            checkOutput($sformatf("%s gy[%0d]", name, i), got_q[i].gy, exp_q[i].gy);
            checkOutput($sformatf("%s eol[%0d]", name, i), got_q[i].eol, exp_q[i].eol);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Plain 2D Sobel reference over img, (r, c) being the bottom-right pixel of the window.
    task automatic pushRefSobel(input int r, input int c, input int w);
        int gx;
        int gy;
        gx = (img[r-2][c] - img[r-2][c-2]) + 2 * (img[r-1][c] - img[r-1][c-2]) + (img[r][c] - img[r][c-2]);
        gy = (img[r][c-2] - img[r-2][c-2]) + 2 * (img[r][c-1] - img[r-2][c-1]) + (img[r][c] - img[r-2][c]);
        pushExp(gx, gy, (c == w - 1) ? 1 : 0);
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            case (ready_mode)
                0:       ready_i = 1'b1;
                1:       ready_i = 1'($urandom_range(0, 1));
                default: ready_i = 1'b0;
            endcase
        end
    end

    // Collect every taken output; a stalled output must reappear unchanged on the next cycle.
    initial begin
        out_t o;
        forever begin
            @(negedge clk_i);
            #2;
            if (!rstn_i) begin
                was_stalled = 1'b0;
            end else begin
                o.gx  = int'(gx_o);
                o.gy  = int'(gy_o);
                o.eol = int'(eol_o);
                if (was_stalled) begin
                    checkOutput("stall valid_o", int'(valid_o), 1);
                    checkOutput("stall gx_o", o.gx, held.gx);
                    checkOutput("stall gy_o", o.gy, held.gy);
                    checkOutput("stall eol_o", o.eol, held.eol);
                end
                if (valid_o && ready_i) begin
                    got_q.push_back(o);
                end
                was_stalled = valid_o && !ready_i;
                held        = o;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no end of test, expected $finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        vec_t vecs[7];
        vecs[0] = '{5,  5,  0, PAT_CONST, 5, 9,  0, 0};
        vecs[1] = '{8,  8,  0, PAT_COL,   5, 18, 8, 0};
        vecs[2] = '{8,  8,  1, PAT_COL,   3, 6,  32, 0};
        vecs[3] = '{6,  6,  2, PAT_ROW10, 5, 12, 0, 60};
        vecs[4] = '{6,  6,  0, PAT_ROW10, 4, 8,  0, 80};
        vecs[5] = '{1,  3,  0, PAT_COL,   4, 2,  8, 0};
        vecs[6] = '{31, 16, 3, PAT_COL,   3, 14, 8, 0};

        rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("reset valid_o", int'(valid_o), 0);
        checkOutput("reset gx_o", int'(gx_o), 0);
        checkOutput("reset gy_o", int'(gy_o), 0);
        checkOutput("reset eol_o", int'(eol_o), 0);
        checkOutput("reset ready_o", int'(ready_o), 1);
        @(negedge clk_i);
        rstn_i = 1'b1;

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < vecs[i].exp_count; j++) begin
                pushExp(vecs[i].exp_gx, vecs[i].exp_gy,
                        ((j % (vecs[i].w_eff - 2)) == (vecs[i].w_eff - 3)) ? 1 : 0);
            end
            sendFrame(vecs[i].pat, vecs[i].width_in, vecs[i].w_eff, vecs[i].mode,
                      vecs[i].rows * vecs[i].w_eff);
            compareAll($sformatf("vec%0d", i));
        end

        // Scharr across a dark-to-bright step between columns 2 and 3.
        pushExp(0, 0, 0);
        pushExp(4080, 0, 0);
        pushExp(4080, 0, 0);
        pushExp(0, 0, 1);
        sendFrame(PAT_STEP, 6, 6, 1, 18);
        compareAll("step");

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 16; c++) begin
                img[r][c] = int'($urandom_range(0, 255));
            end
        end
        for (int pass = 0; pass < 2; pass++) begin
            ready_mode = pass;
            for (int r = 2; r < 6; r++) begin
                for (int c = 2; c < 16; c++) begin
                    pushRefSobel(r, c, 16);
                end
            end
            sendFrame(PAT_RAND, 16, 16, 0, 96);
            compareAll(pass == 0 ? "rand_ready" : "rand_backpressure");
        end
        ready_mode = 0;
        @(negedge clk_i);

        // Frame restart at row 3 col 4 of a W=6 frame, new frame W=4.
        pushExp(0, 0, 0);
        pushExp(0, 0, 0);
        pushExp(0, 0, 0);
        pushExp(0, 0, 1);
        pushExp(0, 0, 0);
        pushExp(0, 0, 0);
        pushExp(0, 160, 0);
        pushExp(0, 160, 1);
        sendFrame(PAT_CONST, 6, 6, 0, 22);
        sendFrame(PAT_ROW20, 4, 4, 0, 12);
        compareAll("sof_midframe");

        // Stall an output mid-row, then reset while it is still pending.
        ready_mode = 2;
        repeat (2) @(negedge clk_i);
        sendFrame(PAT_COL, 6, 6, 0, 15);
        repeat (4) @(negedge clk_i);
        #1;
        checkOutput("stalled valid_o", int'(valid_o), 1);
        checkOutput("stalled gx_o", int'(gx_o), 8);
        checkOutput("stalled ready_o", int'(ready_o), 0);
        @(negedge clk_i);
        rstn_i = 1'b0;
        @(negedge clk_i);
        #1;
        checkOutput("midreset valid_o", int'(valid_o), 0);
        checkOutput("midreset gx_o", int'(gx_o), 0);
        checkOutput("midreset gy_o", int'(gy_o), 0);
        checkOutput("midreset eol_o", int'(eol_o), 0);
        rstn_i     = 1'b1;
        ready_mode = 0;
        repeat (2) @(negedge clk_i);
        pushExp(0, 160, 0);
        pushExp(0, 160, 1);
        sendFrame(PAT_ROW20, 4, 4, 0, 12);
        compareAll("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
Next-generation streaming 3x3 gradient convolver for the Sobel pipeline: one pixel per beat in, registered Gx/Gy out.
- Adds run-time line width, selectable kernel (Sobel / Scharr / Prewitt) and frame-start resynchronisation.
- Window-validity gating: only windows fully inside the image are emitted, so stale line-buffer contents never reach the output.
- Full ready/valid backpressure on both sides; sits between the pixel source and the magnitude/threshold stage.

Parameters:
WIDTH_P, 8, unsigned pixel width in bits (>=5).
DEPTH_P, 16, maximum line width in pixels; line-buffer depth per row (>=3).
CW_P, $clog2(DEPTH_P+1), width of the line-width input and column counter.

Ports:
clk_i  in  1  clock, all logic rising-edge.
rstn_i  in  1  reset, synchronous, active-low.
valid_i  in  1  input pixel valid.
ready_o  out  1  input ready.
data_i  in  WIDTH_P  unsigned pixel.
sof_i  in  1  start of frame; qualifies the beat carrying the first pixel of a frame.
width_i  in  CW_P  active line width; sampled on an accepted sof_i beat.
mode_i  in  2  kernel select (0 Sobel, 1 Scharr, 2 Prewitt, 3 reserved = Sobel); sampled with width_i.
valid_o  out  1  output valid.
ready_i  in  1  downstream ready.
gx_o  out  2*WIDTH_P  signed horizontal gradient.
gy_o  out  2*WIDTH_P  signed vertical gradient.
eol_o  out  1  marks the last output of a row.

Behaviour:
- Reset (rstn_i low at clock edge): valid_o=0, gx_o=0, gy_o=0, eol_o=0; col/row counters=0; window regs=0; width=DEPTH_P; mode=Sobel. Line-buffer RAM contents are not cleared.
- Reset mid-frame: the in-flight output is dropped. No output until a new row pair has been gathered.
- Accept: a beat is accepted when valid_i & ready_o. ready_o = ready_i | ~valid_o, i.e. a single output register with bubble collapse.
- Counters: col increments per accepted beat and wraps to 0 after col==W-1, at which point row increments. Row saturates at 2; no frame-height knowledge is needed.
- sof_i: an accepted sof_i beat forces col=0 and row=0 for that pixel, and latches W and mode. This also applies mid-frame.
- Width clamping: width_i<3 latches as 3; width_i>DEPTH_P latches as DEPTH_P.
- Line buffers: two row delays of W pixels each, indexed by col. Each accepted beat shifts the 3x3 window left.
  - Window top row takes the pixel from 2 rows ago.
  - Window middle row takes the pixel from 1 row ago.
  - Window bottom row takes data_i.
- Window validity: a window is valid when the accepted pixel has row==2 and col>=2.
  - Output count is (W-2) per row from the third row onward.
  - Windows straddling a row wrap are suppressed.
- Output timing: latency is 1 cycle from the accepted beat to valid_o.
  - On the next edge after a valid-window beat, valid_o=1 and gx_o/gy_o/eol_o update.
  - eol_o=1 when the source pixel had col==W-1.
  - If no valid window is accepted and ready_i=1, valid_o clears.
- Stall: while valid_o & ~ready_i, gx_o/gy_o/eol_o/valid_o hold and ready_o=0.
- Arithmetic: pixels are zero-extended to signed 2*WIDTH_P. With column weights [a b a]:
  - Gx = right column weighted sum minus left column weighted sum.
  - Gy = bottom row weighted sum minus top row weighted sum.
  - Weights: Sobel a=1,b=2; Scharr a=3,b=10; Prewitt a=1,b=1.
  - Multiplies are shift-add, combinational ahead of the output register.
  - Worst case is 16*(2^WIDTH_P-1), which fits 2*WIDTH_P signed for WIDTH_P>=5. No saturation is required.
- Simultaneous sof_i with a pending stalled output: the output is held until taken. The new frame's first pixel is accepted only when ready_o=1.

Test Plan:
- Constant 100 image, W=5, 5 rows, Sobel, ready_i=1 -> exactly 9 outputs, all gx=gy=0; eol_o on outputs 3, 6, 9; none before row 2 col 2.
- Pixel=col, W=8, Sobel then new sof with mode=Scharr -> Sobel gx=8, gy=0 (18 outputs over 5 rows); Scharr gx=32, gy=0.
- Pixel=10*row, W=6, Prewitt -> gx=0, gy=60; Sobel gy=80.
- Step image (cols 0-2 = 0, cols 3-5 = 255), W=6, Scharr -> gx=4080 on windows straddling the step, 0 elsewhere; gy=0.
- Random ready_i (50%) over a 16x6 random frame -> output sequence identical to ready_i=1 run; gx_o/gy_o stable while stalled; no beat lost or duplicated.
- sof_i asserted at row 3 col 4 with width_i=4, then 3 rows; plus reset pulse mid-row -> no output until new row 2 col 2; 2 outputs per row; after reset valid_o=0, gx_o=gy_o=0.
